weighted_matrix_arbiter: RTL and testbench

Parametrised successor to the single-cycle matrix arbiter. Keeps least-recently-granted matrix fairness and adds per-requester burst weights, a grant/ack handshake with grant hold across back-pressure, and early release when a requester withdraws. Sits in front of shared resources that take multi-beat transfers, such as memory ports and the search-engine result bus.

---
 rtl/weighted_matrix_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_weighted_matrix_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/weighted_matrix_arbiter.sv
// Weighted least-recently-granted matrix arbiter with grant/ack burst handshake.
// Optional macro MATRIX_ARB_URGENT_EN adds an urgent request vector that pre-filters arbitration.
module weighted_matrix_arbiter #(
  parameter int REQUEST_LINES = 4,
  parameter int WEIGHT_W      = 4,
  localparam int ID_W         = (REQUEST_LINES > 1) ? $clog2(REQUEST_LINES) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic [REQUEST_LINES-1:0]          req,
  input  logic [REQUEST_LINES*WEIGHT_W-1:0] weights,
  input  logic                              ack,
`ifdef MATRIX_ARB_URGENT_EN
  input  logic [REQUEST_LINES-1:0]          urgent,
`endif
  output logic [REQUEST_LINES-1:0]          grant,
  output logic [ID_W-1:0]                   grant_id,
  output logic                              grant_valid,
  output logic [WEIGHT_W-1:0]               beats_left
);

  typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t                                     state_r, state_s;
  logic [REQUEST_LINES-1:0][REQUEST_LINES-1:0] prio_r, prio_s;
  logic [REQUEST_LINES-1:0]                   grant_r, grant_s;
  logic [ID_W-1:0]                            grant_id_r, grant_id_s;
  logic                                       grant_valid_r, grant_valid_s;
  logic [WEIGHT_W-1:0]                        beats_r, beats_s;
  logic [REQUEST_LINES-1:0]                   cand_s, win_s;
  logic [ID_W-1:0]                            win_id_s;
  logic [WEIGHT_W-1:0]                        win_w_s;
  logic                                       urgent_hit_s, take_s, release_s;

  // Reset matrix: higher index beats lower index.
  function automatic logic [REQUEST_LINES-1:0][REQUEST_LINES-1:0] prio_reset();
    logic [REQUEST_LINES-1:0][REQUEST_LINES-1:0] p;
    for (int r = 0; r < REQUEST_LINES; r++) begin
      for (int c = 0; c < REQUEST_LINES; c++) begin
        p[r][c] = (r > c) ? 1'b1 : 1'b0;
      end
    end
    return p;
  endfunction

  // Candidate set: urgent requesters take precedence when any are asserting.
  always_comb begin
`ifdef MATRIX_ARB_URGENT_EN
    urgent_hit_s = |(req & urgent);
    if (urgent_hit_s) begin
      cand_s = req & urgent;
    end else begin
      cand_s = req;
    end
`else
    urgent_hit_s = 1'b0;
    cand_s       = req;
`endif
  end

  // Matrix winner: a candidate that beats every other active candidate.
  always_comb begin
    win_s    = '0;
    win_id_s = '0;
    win_w_s  = '0;
    for (int i = 0; i < REQUEST_LINES; i++) begin
      win_s[i] = cand_s[i];
      for (int j = 0; j < REQUEST_LINES; j++) begin
        if (j != i) begin
          win_s[i] = win_s[i] & (~cand_s[j] | prio_r[i][j]);
        end else begin
          win_s[i] = win_s[i];
        end
      end
      if (win_s[i]) begin
        win_id_s = ID_W'(i);
        win_w_s  = weights[i*WEIGHT_W +: WEIGHT_W];
      end else begin
        win_id_s = win_id_s;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state: issue from IDLE, release on last ack or withdrawn request.
  always_comb begin
    state_s   = state_r;
    take_s    = 1'b0;
    release_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (en && (|req)) begin
          take_s  = 1'b1;
          state_s = HOLD;
        end else begin
          state_s = IDLE;
        end
      end
      HOLD: begin
        if (!req[grant_id_r]) begin
          release_s = 1'b1;
          state_s   = IDLE;
        end else if (ack && (beats_r == WEIGHT_W'(1))) begin
          release_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output and matrix next values; the matrix moves only on release.
  always_comb begin
    grant_s       = grant_r;
    grant_id_s    = grant_id_r;
    grant_valid_s = grant_valid_r;
    beats_s       = beats_r;
    prio_s        = prio_r;
    if (take_s) begin
      grant_s       = win_s;
      grant_id_s    = win_id_s;
      grant_valid_s = 1'b1;
      if (urgent_hit_s || (win_w_s == '0)) begin
        beats_s = WEIGHT_W'(1);
      end else begin
        beats_s = win_w_s;
      end
    end else if (release_s) begin
      grant_s       = '0;
      grant_id_s    = '0;
      grant_valid_s = 1'b0;
      beats_s       = '0;
      for (int r = 0; r < REQUEST_LINES; r++) begin
        for (int c = 0; c < REQUEST_LINES; c++) begin
          if (r == c) begin
            prio_s[r][c] = 1'b0;
          end else if (ID_W'(r) == grant_id_r) begin
            prio_s[r][c] = 1'b0;
          end else if (ID_W'(c) == grant_id_r) begin
            prio_s[r][c] = 1'b1;
          end else begin
            prio_s[r][c] = prio_r[r][c];
          end
        end
      end
    end else if ((state_r == HOLD) && ack) begin
      beats_s = beats_r - WEIGHT_W'(1);
    end else begin
      beats_s = beats_r;
    end
  end

  // Output and matrix registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_r        <= prio_reset();
      grant_r       <= '0;
      grant_id_r    <= '0;
      grant_valid_r <= 1'b0;
      beats_r       <= '0;
    end else begin
      prio_r        <= prio_s;
      grant_r       <= grant_s;
      grant_id_r    <= grant_id_s;
      grant_valid_r <= grant_valid_s;
      beats_r       <= beats_s;
    end
  end

  assign grant       = grant_r;
  assign grant_id    = grant_id_r;
  assign grant_valid = grant_valid_r;
  assign beats_left  = beats_r;

endmodule

// File: tb/tb_weighted_matrix_arbiter.sv
// Directed bench for weighted_matrix_arbiter with a least-recently-granted queue model.
module tb_weighted_matrix_arbiter;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst, en, ack;
  logic [N-1:0]   req;
  logic [N*W-1:0] weights;
`ifdef MATRIX_ARB_URGENT_EN
  logic [N-1:0]   urgent;
`endif
  logic [N-1:0]   grant;
  logic [IW-1:0]  grant_id;
  logic           grant_valid;
  logic [W-1:0]   beats_left;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  weighted_matrix_arbiter #(.REQUEST_LINES(N), .WEIGHT_W(W)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .weights(weights), .ack(ack),
`ifdef MATRIX_ARB_URGENT_EN
    .urgent(urgent),
`endif
    .grant(grant), .grant_id(grant_id), .grant_valid(grant_valid), .beats_left(beats_left)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: queue of requesters, front = highest priority; a released winner goes to the back.
  int order[$];
  bit mv = 1'b0;
  int mid = 0;
  int mb = 0;
  bit started = 1'b0;

  function automatic int pick(input logic [N-1:0] m);
    for (int k = 0; k < order.size(); k++) begin
      if (m[order[k]]) return order[k];
    end
    return 0;
  endfunction

  function automatic logic [31:0] order_code();
    logic [31:0] c = 32'd0;
    for (int k = 0; k < order.size(); k++) c = (c << 4) | order[k];
    return c;
  endfunction

  task automatic model_release();
    for (int k = 0; k < order.size(); k++) begin
      if (order[k] == mid) begin
        order.delete(k);
        break;
      end
    end
    order.push_back(mid);
    mv = 1'b0; mid = 0; mb = 0;
  endtask

  always begin
    logic [N-1:0] m;
    int w;
    @(posedge clk);
    if (rst) begin
      order.delete();
      for (int k = N-1; k >= 0; k--) order.push_back(k);
      mv = 1'b0; mid = 0; mb = 0;
      started = 1'b1;
    end else if (started) begin
      if (mv) begin
        if (!req[mid]) model_release();
        else if (ack) begin
          if (mb == 1) model_release();
          else mb = mb - 1;
        end
      end else if (en && req != '0) begin
        m = req;
`ifdef MATRIX_ARB_URGENT_EN
        if ((req & urgent) != '0) m = req & urgent;
`endif
        mid = pick(m);
        mv  = 1'b1;
        w   = int'(weights[mid*W +: W]);
        mb  = (w == 0) ? 1 : w;
`ifdef MATRIX_ARB_URGENT_EN
        if ((req & urgent) != '0) mb = 1;
`endif
      end
    end
    #1;
    if (started) begin
      chk("grant", grant, mv ? (32'd1 << mid) : 32'd0);
      chk("grant_id", grant_id, mid);
      chk("grant_valid", grant_valid, mv);
      chk("beats_left", beats_left, mb);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  int rr_exp[5] = '{3, 2, 1, 0, 3};

  initial begin
    rst = 1'b1; en = 1'b0; req = '0; ack = 1'b0; weights = {N{4'd1}};
`ifdef MATRIX_ARB_URGENT_EN
    urgent = '0;
`endif
    cyc(); cyc();
    chk("rst_valid", grant_valid, 32'd0);
    chk("rst_grant", grant, 32'd0);
    rst = 1'b0;

    // Round robin with unit weights.
    en = 1'b1; req = 4'b1111; ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("rr_id", grant_id, rr_exp[k]);
      chk("rr_valid", grant_valid, 32'd1);
      cyc();
      chk("rr_bubble", grant_valid, 32'd0);
    end
    req = '0;

    // en low blocks a new grant.
    en = 1'b0; req = 4'b0100;
    cyc();
    chk("en_low", grant_valid, 32'd0);
    req = '0; en = 1'b1;
    cyc();

    // Three-beat burst.
    weights[1*W +: W] = 4'd3; req = 4'b0010; ack = 1'b1;
    for (int b = 3; b >= 1; b--) begin
      cyc();
      chk("burst_grant", grant, 32'h2);
      chk("burst_beats", beats_left, b);
    end
    cyc();
    chk("burst_idle", grant_valid, 32'd0);
    req = '0;

    // Back-pressure: hold with ack low while other inputs move.
    weights[0 +: W] = 4'd2; req = 4'b0001; ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("bp_grant", grant, 32'h1);
      chk("bp_beats", beats_left, 32'd2);
      req = 4'b0101; weights[0 +: W] = 4'd9;
    end
    ack = 1'b1;
    cyc();
    chk("bp_beats1", beats_left, 32'd1);
    cyc();
    chk("bp_release", grant_valid, 32'd0);
    req = '0;

    // Early release on withdrawal.
    weights[2*W +: W] = 4'd5; req = 4'b0110; ack = 1'b1;
    cyc();
    chk("wd_id", grant_id, 32'd2);
    chk("wd_beats5", beats_left, 32'd5);
    cyc(); cyc();
    chk("wd_beats3", beats_left, 32'd3);
    req = 4'b0010;
    cyc();
    chk("wd_release", grant_valid, 32'd0);
    cyc();
    chk("wd_next_id", grant_id, 32'd1);
    chk("model_order_wd", order_code(), 32'h3102);
    req = '0;
    cyc();

    // Reset mid-burst.
    weights[3*W +: W] = 4'd4; req = 4'b1000; ack = 1'b1;
    cyc(); cyc(); cyc();
    chk("mb_beats2", beats_left, 32'd2);
    rst = 1'b1;
    cyc();
    chk("mb_rst_valid", grant_valid, 32'd0);
    chk("mb_rst_beats", beats_left, 32'd0);
    chk("mb_rst_id", grant_id, 32'd0);
    rst = 1'b0;
    cyc();
    chk("mb_regrant_id", grant_id, 32'd3);
    chk("mb_regrant_beats", beats_left, 32'd4);
    chk("model_order_rst", order_code(), 32'h3210);
    req = '0;
    cyc();
    req = 4'b0011;
    cyc();
    chk("mb_matrix_reset", grant_id, 32'd1);
    req = '0;
    cyc();

    // Weight zero behaves as one.
    weights[0 +: W] = 4'd0; req = 4'b0001; ack = 1'b0;
    cyc();
    chk("w0_beats", beats_left, 32'd1);
    ack = 1'b1;
    cyc();
    chk("w0_release", grant_valid, 32'd0);
    req = '0;
    cyc();

`ifdef MATRIX_ARB_URGENT_EN
    rst = 1'b1;
    cyc();
    rst = 1'b0; weights = {N{4'd4}}; req = 4'b1111; urgent = 4'b0001; ack = 1'b1;
    cyc();
    chk("urg_id", grant_id, 32'd0);
    chk("urg_beats", beats_left, 32'd1);
    cyc();
    chk("urg_release", grant_valid, 32'd0);
    urgent = '0;
    cyc();
    chk("urg_next_id", grant_id, 32'd3);
    chk("urg_next_beats", beats_left, 32'd4);
    req = '0;
    cyc();
`endif

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
